// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between the EX stage and the multi-cycle divider.
interface div_unit_if #(parameter int DATA_W = 32);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  logic                  stallreq_o;
  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: radix-2 restoring divider, one quotient bit per clock, {remainder, quotient} result.
module div_unit #(parameter int DATA_W = 32) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);
  localparam int CW = $clog2(DATA_W + 1);
  typedef enum logic [1:0] {FREE, ZERO, ON, END} state_e;
  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d;
  logic                sgn1_q, sgn1_d, sgn2_q, sgn2_d, sdiv_q, sdiv_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   abs1, abs2, quot_fix, rem_fix;
  logic [DATA_W:0]     shifted, diff;
  assign abs1 = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i : bus.opdata1_i;
  assign abs2 = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i : bus.opdata2_i;
  // dvd_q shifts dividend bits out the top while quotient bits enter at the bottom
  assign shifted  = {rem_q, dvd_q[DATA_W-1]};
  assign diff     = shifted - {1'b0, dvs_q};
  assign quot_fix = (sdiv_q && (sgn1_q ^ sgn2_q)) ? -dvd_q : dvd_q;
  assign rem_fix  = (sdiv_q && sgn1_q) ? -rem_q : rem_q;
  assign bus.result_o   = result_q;
  assign bus.ready_o    = ready_q;
  assign bus.stallreq_o = bus.start_i & ~ready_q & ~bus.annul_i;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    sgn1_d   = sgn1_q;
    sgn2_d   = sgn2_q;
    sdiv_d   = sdiv_q;
    result_d = result_q;
    ready_d  = ready_q;
    case (state_q)
      FREE: begin
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_d = ZERO;
          end else begin
            state_d = ON;
            dvd_d   = abs1;
            dvs_d   = abs2;
            sgn1_d  = bus.opdata1_i[DATA_W-1];
            sgn2_d  = bus.opdata2_i[DATA_W-1];
            sdiv_d  = bus.signed_div_i;
            cnt_d   = '0;
            rem_d   = '0;
          end
        end
      end
      ZERO: begin
        state_d  = END;
        result_d = '0;
        ready_d  = 1'b1;
      end
      ON: begin
        if (bus.annul_i) begin
          state_d  = FREE;
          cnt_d    = '0;
          ready_d  = 1'b0;
          result_d = '0;
        end else if (cnt_q == CW'(DATA_W)) begin
          state_d  = END;
          result_d = {rem_fix, quot_fix};
          ready_d  = 1'b1;
        end else begin
          rem_d = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
          dvd_d = {dvd_q[DATA_W-2:0], ~diff[DATA_W]};
          cnt_d = cnt_q + CW'(1);
        end
      end
      END: begin
        if (!bus.start_i) begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: state_d = FREE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FREE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      sgn1_q   <= 1'b0;
      sgn2_q   <= 1'b0;
      sdiv_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      sgn1_q   <= sgn1_d;
      sgn2_q   <= sgn2_d;
      sdiv_q   <= sdiv_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed checks of div_unit latency, results, annul and async reset.
module tb_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  div_unit_if #(.DATA_W(32)) bus ();
  div_unit #(.DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic run_div(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int lat);
    int k;
    int st;
    k = 0;
    st = 0;
    @(negedge clk);
    bus.signed_div_i = s;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b0;
    #1 chk({tag, " stall_on_start"}, 64'(bus.stallreq_o), 64'd1);
    while (k < 60) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        bus.opdata1_i = ~a;
        bus.opdata2_i = b + 32'd1;
      end
      if (bus.ready_o) break;
      if (bus.stallreq_o) st++;
    end
    chk({tag, " ready"}, 64'(bus.ready_o), 64'd1);
    chk({tag, " ready_edge"}, 64'(k - 1), 64'(lat));
    chk({tag, " stall_cycles"}, 64'(st), 64'(lat));
    chk({tag, " result"}, bus.result_o, exp);
    @(negedge clk);
    chk({tag, " hold_ready"}, 64'(bus.ready_o), 64'd1);
    chk({tag, " hold_result"}, bus.result_o, exp);
    chk({tag, " hold_stall"}, 64'(bus.stallreq_o), 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    chk({tag, " drop_ready"}, 64'(bus.ready_o), 64'd0);
    chk({tag, " drop_result"}, bus.result_o, 64'd0);
  endtask
  initial begin
    int r;
    int k;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    #1;
    chk("reset ready", 64'(bus.ready_o), 64'd0);
    chk("reset result", bus.result_o, 64'd0);
    chk("reset stall", 64'(bus.stallreq_o), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_div("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
    run_div("s-7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33);
    run_div("s7_-2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
    run_div("uFFF9_2", 1'b0, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC, 33);
    run_div("div0", 1'b0, 32'h12345678, 32'd0, 64'd0, 1);
    run_div("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
    run_div("uFFFF_1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 33);
    run_div("u5_9", 1'b0, 32'd5, 32'd9, 64'h00000005_00000000, 33);
    // annul after nine iterations, then confirm nothing ever completes
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    repeat (10) @(negedge clk);
    bus.annul_i = 1'b1;
    #1 chk("annul stall", 64'(bus.stallreq_o), 64'd0);
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    r = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.ready_o) r++;
    end
    chk("annul no_ready", 64'(r), 64'd0);
    run_div("after_annul", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
    // async reset with cnt at 20
    @(negedge clk);
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i   = 1'b1;
    repeat (21) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_on ready", 64'(bus.ready_o), 64'd0);
    chk("rst_on result", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_div("after_rst_on", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
    // async reset while a finished result is being held
    @(negedge clk);
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i   = 1'b1;
    k = 0;
    while (!bus.ready_o && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("pre_rst_end ready", 64'(bus.ready_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_end ready", 64'(bus.ready_o), 64'd0);
    chk("rst_end result", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_div("after_rst_end", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for the EX stage, serving the div/divu instructions.
- Produces a 64-bit {remainder, quotient} result for the HI/LO write path.
- While an operation is in flight it raises a stall request; the pipeline controller uses it to freeze PC through EX.
- Radix-2 restoring division, one quotient bit per clock, fixed latency.

Parameters:
- DATA_W, 32, operand width; the iteration count equals DATA_W.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- signed_div_i  input  1  1 = signed division, 0 = unsigned.
- opdata1_i  input  32  dividend.
- opdata2_i  input  32  divisor.
- start_i  input  1  EX requests a division; held high until ready_o is seen.
- annul_i  input  1  cancel the in-flight operation (branch flush / exception).
- result_o  output  64  [63:32] remainder, [31:0] quotient; registered.
- ready_o  output  1  result_o valid; registered.
- stallreq_o  output  1  stall request to the pipeline controller; combinational.

Behaviour:
- Reset (async, rst=1): state=FREE, cnt=0, result_o=0, ready_o=0, internal working registers cleared.
- States: FREE, ZERO, ON, END.
- FREE, start_i=1 and annul_i=0:
  - If opdata2_i==0, go to ZERO.
  - Otherwise go to ON. Latch |dividend| and |divisor|; magnitude is taken only when signed_div_i=1 and the operand MSB is 1. Latch both sign bits and signed_div_i. Clear cnt and the partial remainder.
- FREE, start_i=1 and annul_i=1: stay in FREE.
- ZERO: next edge goes to END with result_o=0 and ready_o=1.
- ON, annul_i=1: go to FREE; cnt=0, ready_o stays 0, result_o stays 0.
- ON, annul_i=0, cnt<32, each edge:
  - Shift the next dividend bit into the partial remainder.
  - Trial-subtract the divisor with a 33-bit subtract (no overflow into the sign).
  - Non-negative difference: quotient bit=1 and keep the difference. Negative: quotient bit=0 and restore.
  - cnt++.
- ON, cnt==32: go to END and register result_o.
  - Signed only: negate the quotient if the dividend and divisor signs differ; the remainder takes the sign of the dividend.
  - Set ready_o=1.
- END: hold result_o and ready_o while start_i=1. When start_i=0, go to FREE and clear ready_o and result_o on that edge.
- Operand changes after start is accepted are ignored; latched copies are used throughout.
- Latency:
  - Edge E0 samples start_i (FREE->ON). Edges E1..E32 run the iterations. Edge E33 enters END; ready_o=1 from E33.
  - Divide-by-zero: E0 FREE->ZERO, ready_o=1 from E1.
- stallreq_o = start_i & ~ready_o & ~annul_i. It is high from the cycle start_i rises up to and excluding the ready cycle, which is 33 cycles for a normal divide.
- Signed overflow 0x80000000 / 0xFFFFFFFF: the magnitude path wraps. Required result: quotient=0x80000000, remainder=0. No trap.
- Reset mid-operation: immediate return to FREE and all outputs 0, regardless of state or cnt.
- start_i deasserted while in ON without annul_i: the operation completes, then END->FREE on the next edge, since start_i is already 0.

Test Plan:
- Unsigned: opdata1=100, opdata2=7, start held -> ready_o rises at E33, result_o=0x00000002_0000000E, stallreq_o high exactly 33 cycles. Drop start_i -> ready_o=0 and result_o=0 next edge.
- Signed: -7 / 2 -> result_o=0xFFFFFFFF_FFFFFFFD (r=-1, q=-3). Also 7 / -2 -> 0x00000001_FFFFFFFD. Also unsigned 0xFFFFFFF9 / 2 -> 0x00000001_7FFFFFFC.
- Divide-by-zero: opdata2=0, start=1 -> ready_o=1 at E1, result_o=0, stallreq_o high for one cycle only.
- Annul: start a divide, assert annul_i at E10 -> state FREE, ready_o never rises, stallreq_o low while annul_i=1. A fresh start afterwards gives the correct result at its own E33.
- Overflow and extremes:
  - Signed 0x80000000 / 0xFFFFFFFF -> 0x00000000_80000000.
  - Unsigned 0xFFFFFFFF / 1 -> 0x00000000_FFFFFFFF.
  - 5 / 9 -> 0x00000005_00000000.
- Async reset: assert rst between edges at cnt=20 -> outputs 0 without waiting for clk. After release, a new 100/7 completes normally.
